pin_owner_arbiter: RTL and testbench

PIN_OWNER_ARBITER -- requirements
Module: pin_owner_arbiter

---
 rtl/pin_owner_arbiter_pkg.sv | 16 +
 rtl/pin_owner_arbiter_rr_pick.sv | 36 +++
 rtl/pin_owner_arbiter.sv | 142 ++++++++++++++
 tb/tb_pin_owner_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_owner_arbiter_pkg.sv
// Shared types and defaults for the shield-pin ownership arbiter.
package pin_owner_arbiter_pkg;
  localparam int unsigned DEF_NUM_PINS = 20;
  localparam int unsigned DEF_NUM_REQ  = 3;
  localparam int unsigned TURN_CYC_MIN = 1;
  localparam int unsigned TURN_CYC_MAX = 15;
  localparam int unsigned OWNER_W      = 2;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_OWN,
    ST_DRAIN
  } state_e;
endpackage

// File: rtl/pin_owner_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module rr_pick
  import pin_owner_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] rr_ptr,
  output logic [OWNER_W-1:0] winner,
  output logic               valid
);
  logic               hi_v;
  logic [OWNER_W-1:0] hi_idx;
  logic [OWNER_W-1:0] lo_idx;

  // hi_* finds the first request at/after the pointer; lo_* is the wrapped fallback.
  always_comb begin
    hi_v   = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        if (!hi_v && (i >= 32'(rr_ptr))) begin
          hi_v   = 1'b1;
          hi_idx = OWNER_W'(i);
        end
        if (!valid) begin
          valid  = 1'b1;
          lo_idx = OWNER_W'(i);
        end
      end
    end
    winner = hi_v ? hi_idx : lo_idx;
  end
endmodule

// File: rtl/pin_owner_arbiter.sv
// Hands the shared shield pin bus to one generator at a time, with all-tristate
// turnaround windows on every ownership change.
module pin_owner_arbiter
  import pin_owner_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PINS = DEF_NUM_PINS,
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [OWNER_W-1:0]           owner_id,
  output logic                         busy,
  input  logic [NUM_REQ*NUM_PINS-1:0]  gen_data_o,
  input  logic [NUM_REQ*NUM_PINS-1:0]  gen_tri_o,
  output logic [NUM_PINS-1:0]          pin_data_o,
  output logic [NUM_PINS-1:0]          pin_tri_o,
  input  logic [NUM_PINS-1:0]          pin_data_i,
  output logic [NUM_PINS-1:0]          gen_data_i
);
  localparam int unsigned TC_EFF = (TURN_CYC < TURN_CYC_MIN) ? TURN_CYC_MIN :
                                   (TURN_CYC > TURN_CYC_MAX) ? TURN_CYC_MAX : TURN_CYC;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TC_EFF - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic [OWNER_W-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_PINS-1:0] pin_data_q, pin_tri_q, gen_data_q;
  logic [NUM_PINS-1:0] sel_data, sel_tri;
  logic [OWNER_W-1:0]  pick_idx;
  logic                pick_valid;
  logic                owner_req;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (ptr_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    owner_req = 1'b0;
    sel_data  = '0;
    sel_tri   = '1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        owner_req = req[i];
        sel_data  = gen_data_o[i*NUM_PINS +: NUM_PINS];
        sel_tri   = gen_tri_o[i*NUM_PINS +: NUM_PINS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_SETTLE;
          owner_d = pick_idx;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_SETTLE: begin
        // A withdrawn request aborts the handoff even on the last settle cycle.
        if (!owner_req) begin
          state_d = ST_IDLE;
          owner_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_OWN;
          ptr_d   = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          owner_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_OWN) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        gnt_d[i] = (owner_d == OWNER_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      pin_data_q <= '0;
      pin_tri_q  <= '1;
      gen_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gen_data_q <= pin_data_i;
      // Pins are driven only while ownership continues, so the cycle entering DRAIN is already tristate.
      if ((state_q == ST_OWN) && (state_d == ST_OWN)) begin
        pin_data_q <= sel_data;
        pin_tri_q  <= sel_tri;
      end else begin
        pin_data_q <= '0;
        pin_tri_q  <= '1;
      end
    end
  end

  assign gnt        = gnt_q;
  assign owner_id   = owner_q;
  assign busy       = (state_q != ST_IDLE);
  assign pin_data_o = pin_data_q;
  assign pin_tri_o  = pin_tri_q;
  assign gen_data_i = gen_data_q;
endmodule

// File: tb/tb_pin_owner_arbiter.sv
// Self-checking bench for pin_owner_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_pin_owner_arbiter;
  localparam int NR = 3;
  localparam int NP = 20;
  localparam int TC = 2;
  localparam int GW = NR * NP;
  localparam logic [NP-1:0] ALL1 = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [1:0]    owner_id;
  logic          busy;
  logic [GW-1:0] gen_data_o, gen_tri_o;
  logic [NP-1:0] pin_data_o, pin_tri_o, pin_data_i, gen_data_i;

  int n_checks = 0;
  int n_pass   = 0;

  pin_owner_arbiter #(.NUM_PINS(NP), .NUM_REQ(NR), .TURN_CYC(TC)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .gnt        (gnt),
    .owner_id   (owner_id),
    .busy       (busy),
    .gen_data_o (gen_data_o),
    .gen_tri_o  (gen_tri_o),
    .pin_data_o (pin_data_o),
    .pin_tri_o  (pin_tri_o),
    .pin_data_i (pin_data_i),
    .gen_data_i (gen_data_i)
  );

  always #5 clk = ~clk;

  // Reference model: owner (-1 = nobody), remaining settle/drain cycles, granted flag.
  int            m_owner = -1;
  int            m_settle = 0;
  int            m_drain = 0;
  int            m_ptr = 0;
  bit            m_granted = 1'b0;
  logic [NR-1:0] e_gnt = '0;
  logic [1:0]    e_owner = '0;
  logic          e_busy = 1'b0;
  logic [NP-1:0] e_pdata = '0;
  logic [NP-1:0] e_ptri = '1;
  logic [NP-1:0] e_gdi = '0;

  function automatic logic [NP-1:0] slice(input logic [GW-1:0] v, input int k);
    return NP'(v >> (k * NP));
  endfunction

  task automatic model_edge();
    bit was_granted;
    int was_owner;
    was_granted = m_granted;
    was_owner   = m_owner;
    if (reset) begin
      m_owner = -1; m_settle = 0; m_drain = 0; m_granted = 1'b0; m_ptr = 0;
      e_pdata = '0; e_ptri = ALL1; e_gdi = '0;
    end else begin
      e_gdi = pin_data_i;
      if (m_granted) begin
        if (!req[m_owner]) begin m_granted = 1'b0; m_drain = TC; end
      end else if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_owner = -1;
      end else if (m_owner >= 0) begin
        if (!req[m_owner]) m_owner = -1;
        else begin
          m_settle--;
          if (m_settle == 0) begin m_granted = 1'b1; m_ptr = (m_owner + 1) % NR; end
        end
      end else begin
        for (int j = 0; j < NR; j++) begin
          if (m_owner < 0 && req[(m_ptr + j) % NR]) begin
            m_owner = (m_ptr + j) % NR;
            m_settle = TC;
          end
        end
      end
      if (was_granted && m_granted) begin
        e_pdata = slice(gen_data_o, was_owner);
        e_ptri  = slice(gen_tri_o, was_owner);
      end else begin
        e_pdata = '0;
        e_ptri  = ALL1;
      end
    end
    e_gnt   = m_granted ? NR'(1 << m_owner) : '0;
    e_owner = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e_busy  = (m_owner >= 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '1;
    gen_data_o = GW'({$urandom(), $urandom()});
    gen_tri_o  = '0;
    pin_data_i = NP'($urandom());
    step(); step();
    n_checks++; if (gnt !== '0) $display("FAIL reset_gnt: got %b want 000", gnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (owner_id !== 2'd0) $display("FAIL reset_owner: got %0d want 0", owner_id); else n_pass++;
    n_checks++; if (pin_tri_o !== ALL1) $display("FAIL reset_tri: got %h want %h", pin_tri_o, ALL1); else n_pass++;
    n_checks++; if (pin_data_o !== '0) $display("FAIL reset_data: got %h want 0", pin_data_o); else n_pass++;
    n_checks++; if (gen_data_i !== '0) $display("FAIL reset_gdi: got %h want 0", gen_data_i); else n_pass++;
    reset = 1'b0; req = '0;
    step();
  endtask

  task automatic test_single();
    logic [NP-1:0] d0, t0;
    gen_data_o = GW'({$urandom(), $urandom()});
    gen_tri_o  = GW'({$urandom(), $urandom()});
    req = 3'b001;
    for (int c = 0; c < TC; c++) begin
      step();
      n_checks++; if (gnt !== '0 || pin_tri_o !== ALL1 || busy !== 1'b1)
        $display("FAIL single_settle%0d: got gnt=%b tri=%h busy=%b want 000/%h/1", c, gnt, pin_tri_o, busy, ALL1);
      else n_pass++;
    end
    step();
    n_checks++; if (gnt !== 3'b001) $display("FAIL single_gnt: got %b want 001", gnt); else n_pass++;
    n_checks++; if (pin_tri_o !== ALL1) $display("FAIL single_first_own_tri: got %h want %h", pin_tri_o, ALL1); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      d0 = slice(gen_data_o, 0); t0 = slice(gen_tri_o, 0);
      step();
      gen_data_o = GW'({$urandom(), $urandom()});
      gen_tri_o  = GW'({$urandom(), $urandom()});
      n_checks++; if (pin_data_o !== d0 || pin_tri_o !== t0)
        $display("FAIL single_pins%0d: got %h/%h want %h/%h", c, pin_data_o, pin_tri_o, d0, t0);
      else n_pass++;
    end
    req = '0;
    for (int c = 0; c < TC; c++) begin
      step();
      n_checks++; if (gnt !== '0 || pin_tri_o !== ALL1 || busy !== 1'b1)
        $display("FAIL single_drain%0d: got gnt=%b tri=%h busy=%b want 000/%h/1", c, gnt, pin_tri_o, busy, ALL1);
      else n_pass++;
    end
    step();
    n_checks++; if (busy !== 1'b0 || owner_id !== 2'd0)
      $display("FAIL single_idle: got busy=%b owner=%0d want 0/0", busy, owner_id);
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic [NR-1:0] order [4];
    logic [NR-1:0] prev_gnt;
    int ng, held, gap, cyc;
    do_reset();
    req = '1; ng = 0; held = 0; gap = 0; cyc = 0; prev_gnt = '0;
    while (ng < 4 && cyc < 300) begin
      step(); cyc++;
      if (gnt !== '0) begin
        if (prev_gnt === '0) begin
          order[ng] = gnt;
          if (ng > 0) begin
            n_checks++; if (gap !== 2*TC + 1) $display("FAIL fair_gap%0d: got %0d want %0d", ng, gap, 2*TC + 1); else n_pass++;
          end
          ng++; held = 0; gap = 0;
        end
        held++;
        if (held == 5) req[owner_id] = 1'b0;
      end else begin
        gap++;
        req = '1;
        n_checks++; if (pin_tri_o !== ALL1) $display("FAIL fair_tri: got %h want %h", pin_tri_o, ALL1); else n_pass++;
      end
      prev_gnt = gnt;
    end
    n_checks++; if (ng != 4) $display("FAIL fair_timeout: got %0d grants want 4", ng); else n_pass++;
    for (int i = 0; i < ng; i++) begin
      n_checks++; if (order[i] !== NR'(1 << (i % NR))) $display("FAIL fair_order%0d: got %b want %b", i, order[i], NR'(1 << (i % NR)));
      else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_abort();
    do_reset();
    req = 3'b010;
    step();
    n_checks++; if (busy !== 1'b1 || owner_id !== 2'd1) $display("FAIL abort_settle: got busy=%b owner=%0d want 1/1", busy, owner_id); else n_pass++;
    step();
    req = 3'b000;
    step();
    n_checks++; if (busy !== 1'b0 || owner_id !== 2'd0) $display("FAIL abort_idle: got busy=%b owner=%0d want 0/0", busy, owner_id); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (gnt !== '0 || pin_tri_o !== ALL1) $display("FAIL abort_quiet%0d: got gnt=%b tri=%h want 000/%h", c, gnt, pin_tri_o, ALL1);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_no_preempt();
    int cyc;
    do_reset();
    req = 3'b001; cyc = 0;
    while (gnt === '0 && cyc < 10) begin step(); cyc++; end
    n_checks++; if (gnt !== 3'b001) $display("FAIL nopre_first: got %b want 001", gnt); else n_pass++;
    req = 3'b101;
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++; if (gnt !== 3'b001) $display("FAIL nopre_hold%0d: got %b want 001", c, gnt); else n_pass++;
    end
    req = 3'b100;
    step();
    n_checks++; if (gnt !== '0) $display("FAIL nopre_release: got %b want 000", gnt); else n_pass++;
    cyc = 0;
    while (gnt === '0 && cyc < 12) begin step(); cyc++; end
    n_checks++; if (gnt !== 3'b100 || cyc !== 2*TC + 1)
      $display("FAIL nopre_next: got %b after %0d want 100 after %0d", gnt, cyc, 2*TC + 1);
    else n_pass++;
    req = '0;
  endtask

  task automatic test_reset_mid_own();
    int cyc;
    do_reset();
    gen_data_o = GW'({$urandom(), $urandom()});
    gen_tri_o  = GW'({$urandom(), $urandom()}) & ~GW'(ALL1);
    req = 3'b001; cyc = 0;
    while (gnt === '0 && cyc < 10) begin step(); cyc++; end
    step();
    n_checks++; if (pin_tri_o !== '0) $display("FAIL rst_own_driven: got %h want 0", pin_tri_o); else n_pass++;
    reset = 1'b1;
    step();
    n_checks++; if (pin_tri_o !== ALL1 || gnt !== '0 || busy !== 1'b0)
      $display("FAIL rst_own: got tri=%h gnt=%b busy=%b want %h/000/0", pin_tri_o, gnt, busy, ALL1);
    else n_pass++;
    reset = 1'b0; req = '0;
    step();
  endtask

  task automatic test_loopback();
    logic [NP-1:0] prev;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      req = (c < 7) ? 3'b001 : 3'b000;
      prev = (c % 2 == 0) ? 20'hA5A5A : 20'h5A5A5;
      pin_data_i = prev;
      step();
      n_checks++; if (gen_data_i !== prev) $display("FAIL loopback%0d: got %h want %h", c, gen_data_i, prev); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = NR'($urandom());
      gen_data_o = GW'({$urandom(), $urandom()});
      gen_tri_o  = GW'({$urandom(), $urandom()});
      pin_data_i = NP'($urandom());
      step();
      n_checks++; if (gnt !== e_gnt) $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, e_gnt); else n_pass++;
      n_checks++; if (owner_id !== e_owner) $display("FAIL rnd_owner c%0d: got %0d want %0d", c, owner_id, e_owner); else n_pass++;
      n_checks++; if (busy !== e_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, e_busy); else n_pass++;
      n_checks++; if (pin_data_o !== e_pdata) $display("FAIL rnd_pdata c%0d: got %h want %h", c, pin_data_o, e_pdata); else n_pass++;
      n_checks++; if (pin_tri_o !== e_ptri) $display("FAIL rnd_ptri c%0d: got %h want %h", c, pin_tri_o, e_ptri); else n_pass++;
      n_checks++; if (gen_data_i !== e_gdi) $display("FAIL rnd_gdi c%0d: got %h want %h", c, gen_data_i, e_gdi); else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; gen_data_o = '0; gen_tri_o = '1; pin_data_i = '0;
    test_reset();
    test_single();
    test_fairness();
    test_abort();
    test_no_preempt();
    test_reset_mid_own();
    test_loopback();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
